regfile_rename_mp: RTL and testbench
====================================

# regfile_rename_mp

Multi-ported architectural register file with a merged rename table (register → ROB tag) for the superscalar core. It sits between decode/issue and the ROB. It supplies operand value, ready flag and producer tag for 2·SLOTS source operands per cycle, and absorbs SLOTS renames and CMTS commits per cycle. This generalises the single-issue regfile to parametrised width, register count, issue width and commit width, and adds three behaviours: intra-group rename forwarding, multi-commit bypass, and commit retention on flush.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural registers; register 0 is hard-wired to zero
- ROB_W, `ROB_LOG, ROB tag width; tag 0 means "no pending producer"
- SLOTS, 2, issue/rename slots per cycle; there are 2·SLOTS read ports
- CMTS, 2, commit ports per cycle; a higher index is younger

Ports (RW = $clog2(NREG), P = 2·SLOTS):
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, state holds
- rs_valid  in  P  read-port enables; ports 2s and 2s+1 belong to slot s
- rs  in  P·RW  source register indices
- rd_val  out  P·XLEN  operand values
- rd_rdy  out  P  operand-ready flags
- rd_tag  out  P·ROB_W  producer tags; 0 when ready or invalid
- ren_valid  in  SLOTS  rename requests
- ren_rd  in  SLOTS·RW  destination registers
- ren_tag  in  SLOTS·ROB_W  allocated ROB ids, always nonzero
- cmt_valid  in  CMTS  commit strobes
- cmt_rd  in  CMTS·RW  commit destinations
- cmt_val  in  CMTS·XLEN  commit values
- cmt_tag  in  CMTS·ROB_W  ROB id of each committing entry
- flush  in  1  mispredict/jump flush

## Operation
- State: value[NREG], tag[NREG]. Both are cleared to 0 by reset.
- Read port p is combinational and resolved in this priority order:
  - Port invalid: val=0, rdy=0, tag=0.
  - rs==0: val=0, rdy=1, tag=0.
  - Intra-group forward: if a lower slot j<s has ren_valid[j] and ren_rd[j]==rs, then rdy=0, tag=ren_tag of the highest such j, val=0.
  - tag[rs]==0: val=value[rs], rdy=1.
  - Commit bypass: if any cmt_valid[c] has cmt_tag[c]==tag[rs], then val=cmt_val of the highest such c, rdy=1, tag=0.
  - Otherwise: rdy=0, tag=tag[rs], val=0.
- Commit: value[cmt_rd] ← cmt_val for valid commits with cmt_rd≠0. If two commits target the same register, the higher index wins. tag[cmt_rd] ← 0 only when tag[cmt_rd]==cmt_tag.
- Rename: tag[ren_rd] ← ren_tag for ren_rd≠0. Rename overrides any commit clear of the same register in the same cycle. If two slots rename the same register, the higher slot wins.
- Flush: every tag ← 0, and renames that cycle are dropped. Commits that cycle still update value[].
- rdy low: no state change, including flush and reset-released updates. Read ports stay combinational.
- value[0] and tag[0] are never written.

## Timing
- Reads have zero latency (combinational). A write is visible on reads in the following cycle.
- A same-cycle commit is visible through the bypass path.
- Reset is asynchronous on the falling edge of rst_n. While in reset, every valid nonzero read returns val=0, rdy=1, tag=0.
- Reset mid-operation discards all pending tags and values.
- Simultaneous flush + rename + commit: tags are all 0, the commit value is written, and the rename is lost.

## Structure
- Package regfile_pkg: RW derivation, the tag-0 "none" constant, and the read-result struct {val, rdy, tag}.
- Sub-module rf_read_port: one instance per port, generated. Inputs are the state arrays plus the rename/commit vectors and the slot index. It implements the priority chain above.
- The top level holds the state arrays and the sequential update loop.

## Test plan
- Reset, then read r5 on port 0 → val=0, rdy=1, tag=0. Read r0 with a rename pending on r0 → still rdy=1, val=0.
- Rename r3→tag 4 at cycle N. Read r3 at N+1 → rdy=0, tag=4. In the same cycle, commit tag 4 with r3=0xDEAD → bypass gives val=0xDEAD, rdy=1. At N+2 → tag[3]=0, val=0xDEAD.
- Slot 0 renames r7→tag 2 while slot 1 reads r7 in the same cycle → port 2 returns rdy=0, tag=2. Port 0 (slot 0) reads r7 → it sees the old state.
- Commit tag 1 to r9 while slot 0 renames r9→tag 6 in the same cycle → next cycle value[9] is committed and tag[9]=6.
- Two commits to r4 (0x11 on c0, 0x22 on c1) → value[4]=0x22. With rename r4→3 pending, flush plus a commit of r2=0x55 → all tags 0 and value[2]=0x55.
- Drop rdy low with rename, commit and flush active → no state change. Pulse rst_n low mid-burst → all tags clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the renaming register file.
//   rw_of()   : index width for a register count
//   TAG_NONE  : ROB tag value meaning "no pending producer"
//   rd_res_t  : read-port result layout {val, rdy, tag} at the default widths
package regfile_pkg;
    localparam int ROB_LOG  = 4;
    localparam int XLEN_DEF = 32;
    localparam int TAG_NONE = 0;

    function automatic int rw_of(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    typedef struct packed {
        logic [XLEN_DEF-1:0] val;
        logic                rdy;
        logic [ROB_LOG-1:0]  tag;
    } rd_res_t;
endpackage

// File: rtl/regfile_rename_mp_read_port.sv
// One combinational operand read port.
//   en/rs                  : port enable and source register
//   reg_val/reg_tag        : architectural state
//   ren_* / cmt_*          : this cycle's rename and commit vectors
//   val/rdy/tag            : resolved operand
// SLOT is the issue slot that owns this port; only renames from lower
// slots in the same group are forwarded into it.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = ROB_LOG,
    parameter int SLOTS = 2,
    parameter int CMTS  = 2,
    parameter int SLOT  = 0,
    localparam int RW   = rw_of(NREG)
) (
    input  logic                             en,
    input  logic [RW-1:0]                    rs,
    input  logic [NREG-1:0][XLEN-1:0]        reg_val,
    input  logic [NREG-1:0][ROB_W-1:0]       reg_tag,
    input  logic [SLOTS-1:0]                 ren_valid,
    input  logic [SLOTS-1:0][RW-1:0]         ren_rd,
    input  logic [SLOTS-1:0][ROB_W-1:0]      ren_tag,
    input  logic [CMTS-1:0]                  cmt_valid,
    input  logic [CMTS-1:0][XLEN-1:0]        cmt_val,
    input  logic [CMTS-1:0][ROB_W-1:0]       cmt_tag,
    output logic [XLEN-1:0]                  val,
    output logic                             rdy,
    output logic [ROB_W-1:0]                 tag
);
    logic              fwd_hit, byp_hit;
    logic [ROB_W-1:0]  fwd_tag, cur_tag;
    logic [XLEN-1:0]   byp_val;

    always_comb begin
        cur_tag = reg_tag[rs];

        // ascending scan: the highest matching older slot wins
        fwd_hit = 1'b0;
        fwd_tag = '0;
        for (int j = 0; j < SLOTS; j++) begin
            if (j < SLOT && ren_valid[j] && ren_rd[j] == rs) begin
                fwd_hit = 1'b1;
                fwd_tag = ren_tag[j];
            end
        end

        // bypass keys on the producer tag only; the youngest commit wins
        byp_hit = 1'b0;
        byp_val = '0;
        for (int c = 0; c < CMTS; c++) begin
            if (cmt_valid[c] && cmt_tag[c] == cur_tag) begin
                byp_hit = 1'b1;
                byp_val = cmt_val[c];
            end
        end

        val = '0;
        rdy = 1'b0;
        tag = '0;
        if (!en) begin
            rdy = 1'b0;
        end else if (rs == '0) begin
            rdy = 1'b1;
        end else if (fwd_hit) begin
            tag = fwd_tag;
        end else if (cur_tag == ROB_W'(TAG_NONE)) begin
            val = reg_val[rs];
            rdy = 1'b1;
        end else if (byp_hit) begin
            val = byp_val;
            rdy = 1'b1;
        end else begin
            tag = cur_tag;
        end
    end
endmodule

// File: rtl/regfile_rename_mp.sv
// Multi-ported register file with merged rename table (reg -> ROB tag).
//   clk, rst_n (async low), rdy (global enable), flush
//   rs_valid/rs -> rd_val/rd_rdy/rd_tag : 2*SLOTS combinational read ports
//   ren_valid/ren_rd/ren_tag            : SLOTS renames per cycle
//   cmt_valid/cmt_rd/cmt_val/cmt_tag    : CMTS commits per cycle (higher = younger)
module regfile_rename_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = ROB_LOG,
    parameter int SLOTS = 2,
    parameter int CMTS  = 2,
    localparam int RW   = rw_of(NREG),
    localparam int P    = 2 * SLOTS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    input  logic [P-1:0]                  rs_valid,
    input  logic [P-1:0][RW-1:0]          rs,
    output logic [P-1:0][XLEN-1:0]        rd_val,
    output logic [P-1:0]                  rd_rdy,
    output logic [P-1:0][ROB_W-1:0]       rd_tag,
    input  logic [SLOTS-1:0]              ren_valid,
    input  logic [SLOTS-1:0][RW-1:0]      ren_rd,
    input  logic [SLOTS-1:0][ROB_W-1:0]   ren_tag,
    input  logic [CMTS-1:0]               cmt_valid,
    input  logic [CMTS-1:0][RW-1:0]       cmt_rd,
    input  logic [CMTS-1:0][XLEN-1:0]     cmt_val,
    input  logic [CMTS-1:0][ROB_W-1:0]    cmt_tag,
    input  logic                          flush
);
    logic [NREG-1:0][XLEN-1:0]  value;
    logic [NREG-1:0][ROB_W-1:0] tag;

    // Order inside the enabled branch sets priority: commits (youngest
    // last), then flush clears all tags, else renames override commit
    // clears (highest slot last).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            tag   <= '0;
        end else if (rdy) begin
            for (int c = 0; c < CMTS; c++) begin
                if (cmt_valid[c] && cmt_rd[c] != '0) begin
                    value[cmt_rd[c]] <= cmt_val[c];
                    if (tag[cmt_rd[c]] == cmt_tag[c])
                        tag[cmt_rd[c]] <= ROB_W'(TAG_NONE);
                end
            end
            if (flush) begin
                tag <= '0;
            end else begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (ren_valid[s] && ren_rd[s] != '0)
                        tag[ren_rd[s]] <= ren_tag[s];
                end
            end
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_port
        rf_read_port #(
            .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W),
            .SLOTS(SLOTS), .CMTS(CMTS), .SLOT(p / 2)
        ) u_port (
            .en       (rs_valid[p]),
            .rs       (rs[p]),
            .reg_val  (value),
            .reg_tag  (tag),
            .ren_valid(ren_valid),
            .ren_rd   (ren_rd),
            .ren_tag  (ren_tag),
            .cmt_valid(cmt_valid),
            .cmt_val  (cmt_val),
            .cmt_tag  (cmt_tag),
            .val      (rd_val[p]),
            .rdy      (rd_rdy[p]),
            .tag      (rd_tag[p])
        );
    end
endmodule

// File: tb/tb_regfile_rename_mp.sv
module tb_regfile_rename_mp;
    localparam int XLEN = 32, RW = 5, TW = 4, S = 2, C = 2, P = 4;

    logic                   clk, rst_n, rdy, flush;
    logic [P-1:0]           rs_valid;
    logic [P-1:0][RW-1:0]   rs;
    logic [P-1:0][XLEN-1:0] rd_val;
    logic [P-1:0]           rd_rdy;
    logic [P-1:0][TW-1:0]   rd_tag;
    logic [S-1:0]           ren_valid;
    logic [S-1:0][RW-1:0]   ren_rd;
    logic [S-1:0][TW-1:0]   ren_tag;
    logic [C-1:0]           cmt_valid;
    logic [C-1:0][RW-1:0]   cmt_rd;
    logic [C-1:0][XLEN-1:0] cmt_val;
    logic [C-1:0][TW-1:0]   cmt_tag;

    int checks = 0, failures = 0;

    regfile_rename_mp dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .rs_valid(rs_valid), .rs(rs),
        .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_tag(rd_tag),
        .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_tag(ren_tag),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    // read port p of register r, then compare all three outputs
    task automatic rd(input string nm, input int p, input int r,
                      input logic [31:0] v, input logic ry, input logic [3:0] t);
        rs_valid[p] = 1'b1;
        rs[p]       = RW'(r);
        #1;
        chk({nm, ".val"}, 64'(rd_val[p]), 64'(v));
        chk({nm, ".rdy"}, 64'(rd_rdy[p]), 64'(ry));
        chk({nm, ".tag"}, 64'(rd_tag[p]), 64'(t));
    endtask

    task automatic idle();
        rs_valid = '0; rs = '0;
        ren_valid = '0; ren_rd = '0; ren_tag = '0;
        cmt_valid = '0; cmt_rd = '0; cmt_val = '0; cmt_tag = '0;
        flush = 1'b0;
    endtask

    task automatic ren(input int s, input int r, input int t);
        ren_valid[s] = 1'b1; ren_rd[s] = RW'(r); ren_tag[s] = TW'(t);
    endtask

    task automatic cmt(input int c, input int r, input logic [31:0] v, input int t);
        cmt_valid[c] = 1'b1; cmt_rd[c] = RW'(r); cmt_val[c] = v; cmt_tag[c] = TW'(t);
    endtask

    // apply the current inputs on the next edge, then start a clean cycle
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        idle();
        #3;
        rd("rst_r5", 0, 5, 32'h0, 1'b1, 4'h0);
        rs_valid = '0;
        #1;
        chk("invalid_rdy", 64'(rd_rdy[0]), 64'h0);
        #8 rst_n = 1'b1;
        tick();

        // r0 read with a rename of r0 pending in an older slot
        ren(0, 0, 5);
        rd("r0_fwd", 2, 0, 32'h0, 1'b1, 4'h0);
        tick();
        rd("r0_after", 0, 0, 32'h0, 1'b1, 4'h0);
        idle();

        // rename r3 -> 4, then commit tag 4 through the bypass
        ren(0, 3, 4);
        tick();
        rd("r3_pend", 0, 3, 32'h0, 1'b0, 4'h4);
        cmt(0, 3, 32'hDEAD, 4);
        rd("r3_byp", 0, 3, 32'hDEAD, 1'b1, 4'h0);
        tick();
        rd("r3_cmt", 0, 3, 32'hDEAD, 1'b1, 4'h0);
        idle();

        // intra-group forward: slot 0 renames r7 -> 2, both slots read r7
        ren(0, 7, 2);
        rd("fwd_p2", 2, 7, 32'h0, 1'b0, 4'h2);
        rd("fwd_p0", 0, 7, 32'h0, 1'b1, 4'h0);
        tick();

        // rename overrides a same-cycle commit clear
        ren(0, 9, 1);
        tick();
        cmt(0, 9, 32'h99, 1);
        ren(0, 9, 6);
        tick();
        rd("r9_ren", 0, 9, 32'h0, 1'b0, 4'h6);
        idle();

        // two commits to r4: younger wins
        cmt(0, 4, 32'h11, 8);
        cmt(1, 4, 32'h22, 9);
        tick();
        rd("r4_dual", 0, 4, 32'h22, 1'b1, 4'h0);
        idle();

        // two commits matching r7's tag: bypass takes the younger value
        cmt(0, 7, 32'hA, 2);
        cmt(1, 7, 32'hB, 2);
        rd("r7_byp2", 1, 7, 32'hB, 1'b1, 4'h0);
        tick();
        rd("r7_cmt", 1, 7, 32'hB, 1'b1, 4'h0);
        idle();

        // flush + commit + rename in one cycle
        ren(0, 4, 3);
        tick();
        rd("r4_pend", 0, 4, 32'h0, 1'b0, 4'h3);
        idle();
        flush = 1'b1;
        cmt(0, 2, 32'h55, 12);
        ren(1, 5, 7);
        tick();
        rd("fl_r4", 0, 4, 32'h22, 1'b1, 4'h0);
        rd("fl_r2", 1, 2, 32'h55, 1'b1, 4'h0);
        rd("fl_r5", 2, 5, 32'h0, 1'b1, 4'h0);
        rd("fl_r9", 3, 9, 32'h99, 1'b1, 4'h0);
        idle();

        // rdy low freezes state
        ren(0, 6, 5);
        tick();
        rdy = 1'b0;
        ren(0, 8, 4);
        cmt(0, 6, 32'h77, 5);
        flush = 1'b1;
        tick();
        rdy = 1'b1;
        rd("hold_r6", 0, 6, 32'h0, 1'b0, 4'h5);
        rd("hold_r8", 1, 8, 32'h0, 1'b1, 4'h0);
        idle();

        // async reset mid-cycle clears everything before any edge
        ren(0, 10, 3);
        tick();
        rd("r10_pend", 0, 10, 32'h0, 1'b0, 4'h3);
        #1 rst_n = 1'b0;
        rd("ar_r10", 0, 10, 32'h0, 1'b1, 4'h0);
        rd("ar_r4", 1, 4, 32'h0, 1'b1, 4'h0);
        #2 rst_n = 1'b1;
        tick();
        rd("post_r6", 0, 6, 32'h0, 1'b1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
